brg_wb2ps_sync_fifo: RTL and testbench

// Single-clock synchronous FIFO for the WB-to-PS bridge write path. It wraps an

---
 rtl/brg_wb2ps_sync_fifo.sv | 166 ++++++++++++++++
 tb/tb_brg_wb2ps_sync_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/brg_wb2ps_sync_fifo.sv
// Single-clock synchronous FIFO for the WB-to-PS bridge write path.
// Simple dual-port RAM with a registered read port that doubles as the output
// register. In standard mode a read returns data one cycle later. In FWFT mode
// the output register is kept filled from RAM, so the head word is always
// presented while !empty.
//
// Handshake: a write is accepted on an edge where wr_en && !full. A read (or
// pop) is accepted on an edge where rd_en && !empty. Requests that are not
// accepted have no effect on pointers, level or data. They only set the
// sticky ovf/udf flags.
module brg_wb2ps_sync_fifo #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 32,
    parameter int FWFT          = 1,
    parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 4,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  afull,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  ovf,
    output logic                  udf,
    input  logic                  clr_err
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
    localparam logic [ADDR_WIDTH:0] ONE_L    = (ADDR_WIDTH+1)'(1);

    // Threshold sanity: reject nonsensical parameter sets at elaboration.
    generate
        if (!((AEMPTY_THRESH > 0) && (AEMPTY_THRESH < AFULL_THRESH) &&
              (AFULL_THRESH <= DEPTH))) begin : g_bad_thresh
            $error("brg_wb2ps_sync_fifo: need 0 < AEMPTY_THRESH < AFULL_THRESH <= DEPTH");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   level_q;
    logic [ADDR_WIDTH:0]   level_nxt;
    logic                  full_q;
    logic                  afull_q;
    logic                  aempty_q;
    logic                  empty_q;     // standard mode: level == 0
    logic                  out_valid;   // FWFT mode: output register holds head
    logic                  rd_valid_q;  // standard mode: one-cycle data strobe
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  ovf_q;
    logic                  udf_q;

    logic                  empty_int;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  ram_has;
    logic                  ram_rd;

    assign empty_int = (FWFT != 0) ? !out_valid : empty_q;
    assign wr_acc    = wr_en && !full_q;
    assign rd_acc    = rd_en && !empty_int;
    assign ram_has   = (wr_ptr != rd_ptr);
    // FWFT refills the output register whenever it is empty or being popped.
    assign ram_rd    = (FWFT != 0) ? (ram_has && (!out_valid || rd_acc)) : rd_acc;

    // Next level: words held in RAM plus the FWFT output register.
    always_comb begin
        level_nxt = level_q;
        if (wr_acc && !rd_acc) begin
            level_nxt = level_q + ONE_L;
        end else if (!wr_acc && rd_acc) begin
            level_nxt = level_q - ONE_L;
        end
    end

    // RAM write port. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
        end
    end

    // Pointers, level and registered flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            empty_q  <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + ONE_L;
            end
            if (ram_rd) begin
                rd_ptr <= rd_ptr + ONE_L;
            end
            level_q  <= level_nxt;
            full_q   <= (level_nxt == DEPTH_L);
            afull_q  <= (level_nxt >= AFULL_L);
            aempty_q <= (level_nxt <= AEMPTY_L);
            empty_q  <= (level_nxt == '0);
        end
    end

    // Registered RAM read port / output register and its valid tracking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data_q  <= '0;
            out_valid  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_acc;
            if (ram_rd) begin
                rd_data_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
                out_valid <= 1'b1;
            end else if (rd_acc) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Sticky error flags; a new error in the same cycle beats clr_err.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && full_q) begin
                ovf_q <= 1'b1;
            end else if (clr_err) begin
                ovf_q <= 1'b0;
            end
            if (rd_en && empty_int) begin
                udf_q <= 1'b1;
            end else if (clr_err) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign full     = full_q;
    assign afull    = afull_q;
    assign aempty   = aempty_q;
    assign empty    = empty_int;
    assign level    = level_q;
    assign rd_data  = rd_data_q;
    assign rd_valid = (FWFT != 0) ? out_valid : rd_valid_q;
    assign ovf      = ovf_q;
    assign udf      = udf_q;

endmodule

// File: tb/tb_brg_wb2ps_sync_fifo.sv
// Bench for brg_wb2ps_sync_fifo: one standard-mode and one FWFT-mode instance
// (16 words each) driven from a single directed sequence plus a random phase.
module tb_brg_wb2ps_sync_fifo;

    localparam int AW = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic clr_err = 1'b0;

    logic          a_wr_en = 1'b0, a_rd_en = 1'b0;
    logic [DW-1:0] a_wr_data = '0;
    logic          a_full, a_afull, a_empty, a_aempty, a_rd_valid, a_ovf, a_udf;
    logic [DW-1:0] a_rd_data;
    logic [AW:0]   a_level;

    logic          b_wr_en = 1'b0, b_rd_en = 1'b0;
    logic [DW-1:0] b_wr_data = '0;
    logic          b_full, b_afull, b_empty, b_aempty, b_rd_valid, b_ovf, b_udf;
    logic [DW-1:0] b_rd_data;
    logic [AW:0]   b_level;

    int checks = 0;
    int failures = 0;

    // Scoreboard state
    logic [DW-1:0] exp_qa[$];
    logic [DW-1:0] exp_qb[$];
    logic [DW-1:0] a_last = '0;
    logic          b_ov = 1'b0;
    logic          m_aovf = 1'b0, m_audf = 1'b0, m_bovf = 1'b0, m_budf = 1'b0;

    // Clock
    always #5 clk = ~clk;

    brg_wb2ps_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_std (
        .clk(clk), .resetn(resetn), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .full(a_full), .afull(a_afull), .rd_en(a_rd_en), .rd_data(a_rd_data),
        .rd_valid(a_rd_valid), .empty(a_empty), .aempty(a_aempty), .level(a_level),
        .ovf(a_ovf), .udf(a_udf), .clr_err(clr_err)
    );

    brg_wb2ps_sync_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_fwft (
        .clk(clk), .resetn(resetn), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .full(b_full), .afull(b_afull), .rd_en(b_rd_en), .rd_data(b_rd_data),
        .rd_valid(b_rd_valid), .empty(b_empty), .aempty(b_aempty), .level(b_level),
        .ovf(b_ovf), .udf(b_udf), .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus on both instances, then model update and checks.
    // Entered and left at a falling edge.
    task automatic cycle(input logic awe, input logic [31:0] awd, input logic are,
                         input logic bwe, input logic [31:0] bwd, input logic bre,
                         input logic clr);
        int an, bn, bram;
        logic awacc, aracc, bwacc, bracc, bnew;
        an    = exp_qa.size();
        bn    = exp_qb.size();
        awacc = awe && (an < 16);
        aracc = are && (an > 0);
        bwacc = bwe && (bn < 16);
        bracc = bre && b_ov;
        bram  = bn - (b_ov ? 1 : 0);
        if (awe && an == 16) m_aovf = 1'b1; else if (clr) m_aovf = 1'b0;
        if (are && an == 0)  m_audf = 1'b1; else if (clr) m_audf = 1'b0;
        if (bwe && bn == 16) m_bovf = 1'b1; else if (clr) m_bovf = 1'b0;
        if (bre && !b_ov)    m_budf = 1'b1; else if (clr) m_budf = 1'b0;

        a_wr_en = awe; a_wr_data = awd; a_rd_en = are;
        b_wr_en = bwe; b_wr_data = bwd; b_rd_en = bre;
        clr_err = clr;
        @(posedge clk);
        @(negedge clk);
        a_wr_en = 1'b0; a_rd_en = 1'b0; b_wr_en = 1'b0; b_rd_en = 1'b0; clr_err = 1'b0;

        if (aracc) a_last = exp_qa.pop_front();
        if (awacc) exp_qa.push_back(awd);
        bnew = (bram > 0) || (b_ov && !bracc);
        if (bracc) void'(exp_qb.pop_front());
        if (bwacc) exp_qb.push_back(bwd);
        b_ov = bnew;

        chk("a_level",    32'(a_level),    32'(exp_qa.size()));
        chk("a_full",     32'(a_full),     32'(exp_qa.size() == 16));
        chk("a_afull",    32'(a_afull),    32'(exp_qa.size() >= 12));
        chk("a_aempty",   32'(a_aempty),   32'(exp_qa.size() <= 4));
        chk("a_empty",    32'(a_empty),    32'(exp_qa.size() == 0));
        chk("a_rd_valid", 32'(a_rd_valid), 32'(aracc));
        chk("a_rd_data",  a_rd_data,       a_last);
        chk("a_ovf",      32'(a_ovf),      32'(m_aovf));
        chk("a_udf",      32'(a_udf),      32'(m_audf));

        chk("b_level",    32'(b_level),    32'(exp_qb.size()));
        chk("b_full",     32'(b_full),     32'(exp_qb.size() == 16));
        chk("b_afull",    32'(b_afull),    32'(exp_qb.size() >= 12));
        chk("b_aempty",   32'(b_aempty),   32'(exp_qb.size() <= 4));
        chk("b_empty",    32'(b_empty),    32'(!b_ov));
        chk("b_rd_valid", 32'(b_rd_valid), 32'(b_ov));
        if (b_ov) chk("b_rd_data", b_rd_data, exp_qb[0]);
        chk("b_ovf",      32'(b_ovf),      32'(m_bovf));
        chk("b_udf",      32'(b_udf),      32'(m_budf));
    endtask

    // Asynchronous reset pulse with immediate and post-release checks.
    task automatic do_reset();
        resetn = 1'b0;
        #1;
        chk("rst_a_level",  32'(a_level),    32'd0);
        chk("rst_a_empty",  32'(a_empty),    32'd1);
        chk("rst_a_aempty", 32'(a_aempty),   32'd1);
        chk("rst_a_full",   32'(a_full),     32'd0);
        chk("rst_a_afull",  32'(a_afull),    32'd0);
        chk("rst_a_rdv",    32'(a_rd_valid), 32'd0);
        chk("rst_a_rdd",    a_rd_data,       32'd0);
        chk("rst_a_err",    32'({a_ovf, a_udf}), 32'd0);
        chk("rst_b_level",  32'(b_level),    32'd0);
        chk("rst_b_empty",  32'(b_empty),    32'd1);
        chk("rst_b_aempty", 32'(b_aempty),   32'd1);
        chk("rst_b_full",   32'(b_full),     32'd0);
        chk("rst_b_afull",  32'(b_afull),    32'd0);
        chk("rst_b_rdv",    32'(b_rd_valid), 32'd0);
        chk("rst_b_rdd",    b_rd_data,       32'd0);
        chk("rst_b_err",    32'({b_ovf, b_udf}), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        exp_qa.delete(); exp_qb.delete();
        a_last = '0; b_ov = 1'b0;
        m_aovf = 1'b0; m_audf = 1'b0; m_bovf = 1'b0; m_budf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rel_a_level", 32'(a_level), 32'd0);
        chk("rel_a_empty", 32'(a_empty), 32'd1);
        chk("rel_b_level", 32'(b_level), 32'd0);
        chk("rel_b_empty", 32'(b_empty), 32'd1);
    endtask

    initial begin
        logic [31:0] d;
        int pw, pr;
        @(negedge clk);
        do_reset();

        // Fill standard FIFO with 0..15
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 32'(i), 1'b0, 1'b0, '0, 1'b0, 1'b0);
            if (i == 10) chk("fill_afull_11", 32'(a_afull), 32'd0);
            if (i == 11) chk("fill_afull_12", 32'(a_afull), 32'd1);
            if (i == 14) chk("fill_full_15",  32'(a_full),  32'd0);
            if (i == 15) chk("fill_full_16",  32'(a_full),  32'd1);
        end
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("ovf_drop_level", 32'(a_level), 32'd16);
        chk("ovf_set",        32'(a_ovf),   32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(a_ovf), 32'd0);

        // Drain: data 0..15 in order, one-cycle rd_valid
        for (int i = 0; i < 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            chk("drain_data",  a_rd_data,        32'(i));
            chk("drain_valid", 32'(a_rd_valid),  32'd1);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("drain_valid_drop", 32'(a_rd_valid), 32'd0);
        chk("drain_hold",       a_rd_data,       32'd15);
        chk("drain_empty",      32'(a_empty),    32'd1);

        // Underflow, tie with clr_err, then clear
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("udf_set_a", 32'(a_udf), 32'd1);
        chk("udf_set_b", 32'(b_udf), 32'd1);
        chk("udf_data",  a_rd_data,  32'd15);
        cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
        chk("udf_tie", 32'(a_udf), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);
        chk("udf_clr_a", 32'(a_udf), 32'd0);
        chk("udf_clr_b", 32'(b_udf), 32'd0);

        // Reset mid-operation discards queued words
        for (int i = 0; i < 5; i++) cycle(1'b1, 32'(200 + i), 1'b0, 1'b1, 32'(300 + i), 1'b0, 1'b0);
        chk("pre_rst_level", 32'(a_level), 32'd5);
        do_reset();

        // FWFT latency
        cycle(1'b0, '0, 1'b0, 1'b1, 32'hA5A5_A5A5, 1'b0, 1'b0);
        chk("fwft_lvl_1",   32'(b_level), 32'd1);
        chk("fwft_empty_1", 32'(b_empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("fwft_empty_2", 32'(b_empty),   32'd0);
        chk("fwft_head",    b_rd_data,      32'hA5A5_A5A5);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("fwft_hold",    b_rd_data,      32'hA5A5_A5A5);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(b_empty), 32'd1);
        chk("fwft_pop_level", 32'(b_level), 32'd0);

        // Back-to-back writes into empty while prefetch pending, bubble-free pops
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h11, 1'b0, 1'b0);
        chk("pf_empty_after_w1", 32'(b_empty), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h22, 1'b0, 1'b0);
        chk("pf_head_w1", b_rd_data, 32'h11);
        cycle(1'b0, '0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
        chk("pf_level_3", 32'(b_level), 32'd3);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("pf_pop1_data",  b_rd_data,       32'h22);
        chk("pf_pop1_valid", 32'(b_rd_valid), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("pf_pop2_data",  b_rd_data,       32'h33);
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
        chk("pf_pop3_empty", 32'(b_empty),    32'd1);

        // Concurrent read+write at level 8 across pointer wrap (both modes)
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(100 + i), 1'b0, 1'b1, 32'(500 + i), 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            d = $urandom;
            cycle(1'b1, d, 1'b1, 1'b1, ~d, 1'b1, 1'b0);
            chk("conc_a_level", 32'(a_level), 32'd8);
            chk("conc_b_level", 32'(b_level), 32'd8);
        end
        // Top up to full, then write+read while full
        for (int i = 0; i < 8; i++) cycle(1'b1, 32'(700 + i), 1'b0, 1'b1, 32'(800 + i), 1'b0, 1'b0);
        chk("conc_full_a", 32'(a_full), 32'd1);
        chk("conc_full_b", 32'(b_full), 32'd1);
        cycle(1'b1, 32'hBAD0_0001, 1'b1, 1'b1, 32'hBAD0_0002, 1'b1, 1'b0);
        chk("full_wr_rd_level_a", 32'(a_level), 32'd15);
        chk("full_wr_rd_level_b", 32'(b_level), 32'd15);
        chk("full_wr_rd_ovf_a",   32'(a_ovf),   32'd1);
        for (int i = 0; i < 15; i++) cycle(1'b0, '0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
        chk("conc_tail_a", a_rd_data, 32'(707));
        cycle(1'b0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1);

        // Random traffic against the scoreboard, phased fill/drain/balanced
        for (int k = 0; k < 10000; k++) begin
            case ((k / 500) % 3)
                0:       begin pw = 80; pr = 30; end
                1:       begin pw = 30; pr = 80; end
                default: begin pw = 60; pr = 60; end
            endcase
            cycle(32'($urandom_range(0, 99)) < 32'(pw), $urandom,
                  32'($urandom_range(0, 99)) < 32'(pr),
                  32'($urandom_range(0, 99)) < 32'(pw), $urandom,
                  32'($urandom_range(0, 99)) < 32'(pr),
                  $urandom_range(0, 63) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
